// File: rtl/fifo_frame_reader.sv
// Read-side frame consumer for the feature-map FIFO: drains one H-word frame into a
// valid/ready stream with row/col position and frame markers, via a 2-entry skid buffer.
`timescale 1ns/1ps

module fifo_frame_reader #(
    parameter int unsigned H    = 784,
    parameter int unsigned W    = 32,
    parameter int unsigned COLS = 28,
    parameter int unsigned L    = $clog2(H + 1)
) (
    input  logic         rclk,
    input  logic         rrst_b,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] fifo_dout,
    input  logic         fifo_rempty,
    output logic         fifo_re,
    output logic         fifo_rclr,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_sof,
    output logic         m_eol,
    output logic         m_eof,
    output logic [L-1:0] m_row,
    output logic [L-1:0] m_col,
    output logic         busy,
    output logic         done
);

    localparam logic [L-1:0] FRAME_LEN = L'(H);
    localparam logic [L-1:0] LAST_BEAT = L'(H - 1);
    localparam logic [L-1:0] LAST_COL  = L'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic [L-1:0]   rd_cnt;
    logic [L-1:0]   out_cnt;
    logic [L-1:0]   row;
    logic [L-1:0]   col;

    logic [W-1:0]   buf0;
    logic [W-1:0]   buf1;
    logic [1:0]     occ;
    logic           infl;
    logic           rclr_q;

    logic           pop;
    logic           push;
    logic           frame_start;
    logic [2:0]     level;
    logic           room;
    logic           re_int;

    assign pop         = m_valid & m_ready;
    assign push        = infl;
    assign frame_start = (state == S_IDLE) & start & ~abort;

    // Credit check: entries held plus the one in flight, net of this cycle's pop, must leave a slot.
    assign level  = 3'(occ) + 3'(infl);
    assign room   = level < (3'd2 + 3'(pop));
    assign re_int = (state == S_RUN) & ~abort & ~fifo_rempty & (rd_cnt < FRAME_LEN) & room;

    always_ff @(posedge rclk or negedge rrst_b) begin
        if (!rrst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (pop && (out_cnt == LAST_BEAT)) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (abort) begin
            state_nx = S_IDLE;
        end
    end

    // Frame position and read-issue counters.
    always_ff @(posedge rclk or negedge rrst_b) begin
        if (!rrst_b) begin
            rd_cnt  <= '0;
            out_cnt <= '0;
            row     <= '0;
            col     <= '0;
        end else if (frame_start) begin
            rd_cnt  <= '0;
            out_cnt <= '0;
            row     <= '0;
            col     <= '0;
        end else begin
            if (re_int) begin
                rd_cnt <= rd_cnt + L'(1);
            end
            if (pop && !abort) begin
                out_cnt <= out_cnt + L'(1);
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + L'(1);
                end else begin
                    col <= col + L'(1);
                end
            end
        end
    end

    // Two-entry skid buffer; buf0 is always the head. Abort drops contents and in-flight data.
    always_ff @(posedge rclk or negedge rrst_b) begin
        if (!rrst_b) begin
            buf0 <= '0;
            buf1 <= '0;
            occ  <= '0;
            infl <= 1'b0;
        end else if (abort) begin
            occ  <= '0;
            infl <= 1'b0;
        end else begin
            infl <= re_int;
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0 <= fifo_dout;
                    end else begin
                        buf1 <= fifo_dout;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= fifo_dout;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_dout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_b) begin
        if (!rrst_b) begin
            rclr_q <= 1'b0;
        end else begin
            rclr_q <= abort;
        end
    end

    assign fifo_re   = re_int;
    assign fifo_rclr = rclr_q;
    assign m_valid   = (occ != 2'd0);
    assign m_data    = buf0;
    assign m_sof     = m_valid & (out_cnt == '0);
    assign m_eol     = m_valid & (col == LAST_COL);
    assign m_eof     = m_valid & (out_cnt == LAST_BEAT);
    assign m_row     = row;
    assign m_col     = col;
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Randomized bench for fifo_frame_reader: queue-based FIFO model plus an index-derived
// reference for every accepted beat (data, markers, row/col).
`timescale 1ns/1ps

module tb_fifo_frame_reader;

    localparam int unsigned H    = 784;
    localparam int unsigned W    = 32;
    localparam int unsigned COLS = 28;
    localparam int unsigned L    = 10;

    logic         rclk;
    logic         rrst_b;
    logic         start;
    logic         abort;
    logic [W-1:0] fifo_dout;
    logic         fifo_rempty;
    logic         fifo_re;
    logic         fifo_rclr;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_sof;
    logic         m_eol;
    logic         m_eof;
    logic [L-1:0] m_row;
    logic [L-1:0] m_col;
    logic         busy;
    logic         done;

    fifo_frame_reader #(.H(H), .W(W), .COLS(COLS), .L(L)) dut (
        .rclk        (rclk),
        .rrst_b      (rrst_b),
        .start       (start),
        .abort       (abort),
        .fifo_dout   (fifo_dout),
        .fifo_rempty (fifo_rempty),
        .fifo_re     (fifo_re),
        .fifo_rclr   (fifo_rclr),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sof       (m_sof),
        .m_eol       (m_eol),
        .m_eof       (m_eof),
        .m_row       (m_row),
        .m_col       (m_col),
        .busy        (busy),
        .done        (done)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic [W-1:0] q[$];
    int unsigned  next_seq;
    int unsigned  frame_base;
    int unsigned  beat_k;
    int           cyc;
    int           start_cyc;
    int           first_hs;
    int           last_hs;
    int           done_cnt;
    int           done_cyc;
    int           re_cnt;
    int           re_viol;
    int           stab_viol;
    int           fill_left;
    int unsigned  ready_pct;
    logic         re_s;
    logic         rclr_s;
    logic         prev_stall;
    logic [W-1:0] prev_data;
    int           n_tests;
    int           n_fail;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Beat k of a frame: data is the k-th word queued for that frame, position from k alone.
    function automatic logic [63:0] exp_beat(input int unsigned k);
        return {9'd0, W'(frame_base + k), (k == 0), ((k % COLS) == COLS - 1), (k == H - 1),
                L'(k / COLS), L'(k % COLS)};
    endfunction

    function automatic logic [63:0] zero_vec();
        return 64'({fifo_re, fifo_rclr, m_data, m_valid, m_sof, m_eol, m_eof,
                    m_row, m_col, busy, done});
    endfunction

    task automatic preload(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            q.push_back(W'(next_seq));
            next_seq++;
        end
        fifo_rempty = (q.size() == 0);
    endtask

    // Sample just after the falling edge, then advance one cycle and update the FIFO model.
    task automatic tick();
        logic [63:0] obs;
        #1;
        if (fifo_re) begin
            re_cnt++;
            if (fifo_rempty) re_viol++;
        end
        re_s   = fifo_re;
        rclr_s = fifo_rclr;
        if (prev_stall && (!m_valid || m_data !== prev_data)) stab_viol++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (m_valid && m_ready) begin
            obs = {9'd0, m_data, m_sof, m_eol, m_eof, m_row, m_col};
            check_eq("beat", obs, exp_beat(beat_k));
            if (beat_k == 0) first_hs = cyc;
            last_hs = cyc;
            beat_k++;
        end
        @(posedge rclk);
        @(negedge rclk);
        cyc++;
        start = 1'b0;
        abort = 1'b0;
        if (rclr_s) q.delete();
        if (re_s && q.size() != 0) fifo_dout = q.pop_front();
        if (fill_left > 0 && (cyc % 3) == 0) begin
            q.push_back(W'(next_seq));
            next_seq++;
            fill_left--;
        end
        fifo_rempty = (q.size() == 0);
        m_ready = ($urandom_range(99) < ready_pct);
    endtask

    task automatic begin_frame();
        frame_base = (q.size() != 0) ? int'(q[0]) : next_seq;
        beat_k     = 0;
        re_cnt     = 0;
        re_viol    = 0;
        stab_viol  = 0;
        done_cnt   = 0;
        done_cyc   = -1;
        first_hs   = -1;
        last_hs    = -1;
        start_cyc  = cyc;
        start      = 1'b1;
        tick();
    endtask

    task automatic run_until(input int unsigned n, input int budget);
        int i;
        i = 0;
        while (beat_k < n && i < budget) begin
            tick();
            i++;
        end
        check_eq("beat_count", 64'(beat_k), 64'(n));
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        #1;
        check_eq("abort_flush", 64'({fifo_rclr, m_valid, fifo_re, busy, done}), 64'(5'b10000));
        prev_stall = 1'b0;
        tick();
        #1;
        check_eq("rclr_pulse", 64'(fifo_rclr), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; next_seq = 0; fill_left = 0; ready_pct = 100;
        frame_base = 0; beat_k = 0; prev_stall = 1'b0; prev_data = '0; re_s = 1'b0; rclr_s = 1'b0;
        done_cnt = 0; done_cyc = -1; re_cnt = 0; re_viol = 0; stab_viol = 0;
        first_hs = -1; last_hs = -1; start_cyc = 0;
        rrst_b = 1'b1; start = 1'b0; abort = 1'b0; fifo_dout = '0; fifo_rempty = 1'b1; m_ready = 1'b0;
        #1 rrst_b = 1'b0;
        #2 check_eq("reset_outputs", zero_vec(), 64'd0);
        repeat (3) @(negedge rclk);
        rrst_b = 1'b1;

        // 1: preloaded frame, always ready
        preload(H);
        m_ready = 1'b1;
        begin_frame();
        run_until(H, 2000);
        repeat (3) tick();
        check_eq("t1_latency", 64'(first_hs - start_cyc), 64'd3);
        check_eq("t1_contiguous", 64'(last_hs - first_hs), 64'(H - 1));
        check_eq("t1_done_count", 64'(done_cnt), 64'd1);
        check_eq("t1_done_cycle", 64'(done_cyc), 64'(last_hs + 1));
        check_eq("t1_reads", 64'(re_cnt), 64'(H));
        check_eq("t1_idle", 64'({busy, m_valid}), 64'd0);

        // 2: random backpressure
        preload(H);
        ready_pct = 50;
        begin_frame();
        run_until(H, 6000);
        repeat (3) tick();
        check_eq("t2_stable", 64'(stab_viol), 64'd0);
        check_eq("t2_no_underflow", 64'(re_viol), 64'd0);
        check_eq("t2_reads", 64'(re_cnt), 64'(H));
        check_eq("t2_done_count", 64'(done_cnt), 64'd1);

        // 3: slow producer, one word every third cycle
        ready_pct = 100;
        m_ready = 1'b1;
        fill_left = H;
        begin_frame();
        run_until(H, 4000);
        repeat (3) tick();
        check_eq("t3_no_underflow", 64'(re_viol), 64'd0);
        check_eq("t3_reads", 64'(re_cnt), 64'(H));
        check_eq("t3_done_count", 64'(done_cnt), 64'd1);

        // 4: FIFO holds more than a frame
        preload(H + 16);
        begin_frame();
        run_until(H, 2000);
        repeat (5) tick();
        check_eq("t4_reads", 64'(re_cnt), 64'(H));
        check_eq("t4_left", 64'(q.size()), 64'd16);
        check_eq("t4_head", 64'(q[0]), 64'(frame_base + H));
        begin_frame();
        run_until(16, 200);
        repeat (20) tick();
        check_eq("t4_second_beats", 64'(beat_k), 64'd16);
        check_eq("t4_stalled", 64'({m_valid, busy}), 64'(2'b01));
        check_eq("t4_second_reads", 64'(re_cnt), 64'd16);
        check_eq("t4_no_underflow", 64'(re_viol), 64'd0);
        do_abort();

        // 5: abort at beat 300 with the buffer full and no ready
        preload(H);
        begin_frame();
        run_until(300, 1000);
        ready_pct = 0;
        m_ready = 1'b0;
        repeat (4) tick();
        check_eq("t5_held", 64'({m_valid, busy}), 64'(2'b11));
        do_abort();
        repeat (5) tick();
        check_eq("t5_no_done", 64'(done_cnt), 64'd0);
        check_eq("t5_idle", 64'({busy, m_valid, fifo_re}), 64'd0);
        check_eq("t5_beats", 64'(beat_k), 64'd300);
        preload(H);
        ready_pct = 100;
        m_ready = 1'b1;
        begin_frame();
        run_until(H, 2000);
        repeat (3) tick();
        check_eq("t5_restart_done", 64'(done_cnt), 64'd1);

        // 6: asynchronous reset mid-frame
        preload(H);
        ready_pct = 50;
        begin_frame();
        run_until(100, 1000);
        check_eq("t6_busy", 64'(busy), 64'd1);
        @(posedge rclk);
        #2 rrst_b = 1'b0;
        #1 check_eq("t6_async_reset", zero_vec(), 64'd0);
        @(negedge rclk);
        @(negedge rclk);
        rrst_b = 1'b1;
        q.delete();
        preload(H);
        prev_stall = 1'b0;
        ready_pct = 100;
        m_ready = 1'b1;
        begin_frame();
        run_until(H, 2000);
        repeat (3) tick();
        check_eq("t6_done_count", 64'(done_cnt), 64'd1);
        check_eq("t6_reads", 64'(re_cnt), 64'(H));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
